// File: rtl/alib_points_fifo_arbiter.sv
// Purpose : packet-locked round-robin arbiter that feeds one 3D-point FIFO write port from NUM_REQ producers.
// Latency : one arbitration bubble cycle per grant; while locked, the owner's point passes combinationally to the FIFO.
// Backpr. : fifo_full drops req_ready and fifo_wr_en; the grant and its burst count hold until the FIFO has room.
//
// Ports   : clk, rst (async, active-low)
//           req_valid/req_last/req_ready  per-requester handshake; req_x/y/z are 16-bit slices, requester i at [16i+15:16i]
//           fifo_full in; fifo_wr_en, fifo_x/y/z_out drive the FIFO write port (zero when not locked)
//           grant_id (meaningful while busy), busy (1 while locked)
//           stat_clear, stat_count  per-requester transfer counters, slice i at [16i+15:16i]
// Build   : define ALIB_POINTS_ARB_STATS_EN to build saturating 16-bit transfer counters;
//           without it stat_count reads 0 and stat_clear is ignored (same port list).
module alib_points_fifo_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [16*NUM_REQ-1:0]   req_x,
  input  logic [16*NUM_REQ-1:0]   req_y,
  input  logic [16*NUM_REQ-1:0]   req_z,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [15:0]             fifo_x_out,
  output logic [15:0]             fifo_y_out,
  output logic [15:0]             fifo_z_out,
  output logic [2:0]              grant_id,
  output logic                    busy,
  input  logic                    stat_clear,
  output logic [16*NUM_REQ-1:0]   stat_count
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;

  logic        locked;
  logic        sel_valid;
  logic        sel_last;
  logic [15:0] sel_x, sel_y, sel_z;
  logic        xfer;
  logic        burst_end;
  logic        grant_done;

  logic        found;
  logic [2:0]  winner;
  logic [3:0]  scan_idx;

  assign locked = (state_q == ST_LOCKED);

  // Owner's lane, selected with constant slice indices so widths stay exact.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_z     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_x     = req_x[16*i +: 16];
        sel_y     = req_y[16*i +: 16];
        sel_z     = req_z[16*i +: 16];
      end
    end
  end

  assign xfer       = locked & sel_valid & ~fifo_full;
  assign burst_end  = ((burst_cnt_q + 16'd1) == 16'(MAX_BURST));
  assign grant_done = xfer & (sel_last | burst_end);

  // Round-robin scan: candidate k is (rr_ptr + k) mod NUM_REQ; the first valid candidate wins.
  // The 4-bit sum covers rr_ptr + k < 2*NUM_REQ <= 16.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 4'(k);
      if (scan_idx >= 4'(NUM_REQ)) begin
        scan_idx = scan_idx - 4'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (scan_idx == 4'(i))) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d     = ST_LOCKED;
        grant_id_d  = winner;
        burst_cnt_d = '0;
      end
    end else begin
      if (xfer) begin
        burst_cnt_d = burst_cnt_q + 16'd1;
      end
      // Only a transfer can end a grant; an idle or stalled owner keeps it.
      if (grant_done) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = locked & (grant_id_q == 3'(i)) & ~fifo_full;
    end
  end

  assign fifo_wr_en = xfer;
  assign fifo_x_out = locked ? sel_x : 16'd0;
  assign fifo_y_out = locked ? sel_y : 16'd0;
  assign fifo_z_out = locked ? sel_z : 16'd0;
  assign grant_id   = grant_id_q;
  assign busy       = locked;

`ifdef ALIB_POINTS_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear) begin
        stat_d[i] = '0;
      end else if (xfer && (grant_id_q == 3'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_count[16*i +: 16] = stat_q[i];
    end
  end
`else
  logic stat_clear_unused;
  assign stat_clear_unused = stat_clear;
  assign stat_count        = '0;
`endif

endmodule

// File: tb/tb_alib_points_fifo_arbiter.sv
// Bench for alib_points_fifo_arbiter: two instances (MAX_BURST=64 and MAX_BURST=4) driven from one
// requester model; use_b selects which instance is stimulated and observed.
module tb_alib_points_fifo_arbiter;
  localparam int NR = 4;

  typedef struct packed {
    logic        last;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } pt_t;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            use_b;
  logic [NR-1:0]   drv_valid, drv_last;
  logic [16*NR-1:0] drv_x, drv_y, drv_z;
  logic            drv_full, drv_clr;

  logic [NR-1:0]   a_valid, b_valid;
  logic [NR-1:0]   a_rdy, b_rdy;
  logic            a_wr, b_wr, a_busy, b_busy;
  logic [15:0]     a_x, a_y, a_z, b_x, b_y, b_z;
  logic [2:0]      a_gid, b_gid;
  logic [16*NR-1:0] a_stat, b_stat;

  logic [NR-1:0]   o_rdy;
  logic            o_wr, o_busy;
  logic [15:0]     o_x, o_y, o_z;
  logic [2:0]      o_gid;
  logic [16*NR-1:0] o_stat;

  assign a_valid = use_b ? '0 : drv_valid;
  assign b_valid = use_b ? drv_valid : '0;
  assign o_rdy   = use_b ? b_rdy  : a_rdy;
  assign o_wr    = use_b ? b_wr   : a_wr;
  assign o_busy  = use_b ? b_busy : a_busy;
  assign o_x     = use_b ? b_x    : a_x;
  assign o_y     = use_b ? b_y    : a_y;
  assign o_z     = use_b ? b_z    : a_z;
  assign o_gid   = use_b ? b_gid  : a_gid;
  assign o_stat  = use_b ? b_stat : a_stat;

  alib_points_fifo_arbiter #(.NUM_REQ(NR), .MAX_BURST(64)) dut (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_last(drv_last),
    .req_x(drv_x), .req_y(drv_y), .req_z(drv_z), .req_ready(a_rdy),
    .fifo_full(drv_full), .fifo_wr_en(a_wr), .fifo_x_out(a_x), .fifo_y_out(a_y),
    .fifo_z_out(a_z), .grant_id(a_gid), .busy(a_busy), .stat_clear(drv_clr),
    .stat_count(a_stat)
  );

  alib_points_fifo_arbiter #(.NUM_REQ(NR), .MAX_BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_last(drv_last),
    .req_x(drv_x), .req_y(drv_y), .req_z(drv_z), .req_ready(b_rdy),
    .fifo_full(drv_full), .fifo_wr_en(b_wr), .fifo_x_out(b_x), .fifo_y_out(b_y),
    .fifo_z_out(b_z), .grant_id(b_gid), .busy(b_busy), .stat_clear(drv_clr),
    .stat_count(b_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pt_t  src_q [NR][$];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;

  function automatic pt_t mk_pt(input int r, input int v, input logic last);
    pt_t p;
    p.last = last;
    p.x    = 16'(v);
    p.y    = 16'(v) ^ 16'h5A5A;
    p.z    = 16'h1000 + 16'(r);
    return p;
  endfunction

  task automatic push_src(input int r, input int n, input int base);
    for (int k = 0; k < n; k++) src_q[r].push_back(mk_pt(r, base + k, k == n - 1));
  endtask

  task automatic push_exp(input int r, input int n, input int base);
    pt_t  p;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      p    = mk_pt(r, base + k, 1'b0);
      e.id = 3'(r);
      e.x  = p.x;
      e.y  = p.y;
      e.z  = p.z;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    pt_t p;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        p = src_q[i][0];
        drv_valid[i] = 1'b1;
        drv_last[i]  = p.last;
        drv_x[16*i +: 16] = p.x;
        drv_y[16*i +: 16] = p.y;
        drv_z[16*i +: 16] = p.z;
      end else begin
        drv_valid[i] = 1'b0;
        drv_last[i]  = 1'b0;
        drv_x[16*i +: 16] = '0;
        drv_y[16*i +: 16] = '0;
        drv_z[16*i +: 16] = '0;
      end
    end
  endtask

  // One clock: sample at negedge (scoreboard pop on each FIFO write), then advance sources at posedge+1.
  task automatic step();
    logic [NR-1:0] acc;
    exp_t          e;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    acc = drv_valid & o_rdy;
    if (o_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got id=%0d x=%h, want no write", o_gid, o_x);
      end else begin
        e       = exp_q.pop_front();
        exp_rdy = 4'b0001 << e.id;
        if ({o_gid, o_x, o_y, o_z, o_rdy} !== {e.id, e.x, e.y, e.z, exp_rdy}) begin
          errors++;
          $display("FAIL fifo_write got id=%0d x=%h y=%h z=%h rdy=%b, want id=%0d x=%h y=%h z=%h rdy=%b",
                   o_gid, o_x, o_y, o_z, o_rdy, e.id, e.x, e.y, e.z, exp_rdy);
        end
      end
      writes++;
      last_wr_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
    drive();
    cyc++;
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < max_cyc)) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d points outstanding, want 0", name, exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drv_full = 1'b0;
    drv_clr  = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_wr, a_rdy, a_gid} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b wr=%b rdy=%b gid=%0d, want all 0", a_busy, a_wr, a_rdy, a_gid);
    end
    checks++;
    if ({a_x, a_y, a_z} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data got %h, want 0", {a_x, a_y, a_z});
    end
    checks++;
    if ({a_stat, b_stat} !== '0) begin
      errors++;
      $display("FAIL reset_stat got %h %h, want 0", a_stat, b_stat);
    end
    checks++;
    if ({b_busy, b_wr, b_rdy} !== 6'd0) begin
      errors++;
      $display("FAIL reset_b got busy=%b wr=%b rdy=%b, want 0", b_busy, b_wr, b_rdy);
    end
    do_reset();
  endtask

  task automatic test_single();
    int w0;
    use_b = 1'b0;
    do_reset();
    push_src(2, 3, 1);
    push_exp(2, 3, 1);
    drive();
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble got busy=%b, want 0", o_busy);
    end
    step();
    checks++;
    if ({o_busy, o_gid} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL single_grant got busy=%b gid=%0d, want busy=1 gid=2", o_busy, o_gid);
    end
    w0 = writes;
    repeat (3) step();
    checks++;
    if (writes - w0 != 3) begin
      errors++;
      $display("FAIL single_consecutive got %0d writes, want 3", writes - w0);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release got busy=%b, want 0", o_busy);
    end
    // rr_ptr is now 3: with requesters 0 and 3 both pending, 3 must win first.
    push_src(0, 1, 50);
    push_src(3, 1, 60);
    push_exp(3, 1, 60);
    push_exp(0, 1, 50);
    drive();
    drain(40, "single_rr");
  endtask

  task automatic test_round_robin();
    int t0;
    use_b = 1'b0;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      push_src(i, 2, 16 * i);
      push_src(i, 2, 16 * i + 2);
    end
    for (int g = 0; g < 2; g++) for (int i = 0; i < NR; i++) push_exp(i, 2, 16 * i + 2 * g);
    drive();
    t0 = cyc;
    drain(100, "round_robin");
    checks++;
    if (last_wr_cyc - t0 != 23) begin
      errors++;
      $display("FAIL rr_timing got last write at +%0d cycles, want +23", last_wr_cyc - t0);
    end
  endtask

  task automatic test_burst_limit();
    use_b = 1'b1;
    do_reset();
    push_src(0, 10, 0);
    push_src(1, 3, 100);
    push_src(1, 3, 103);
    push_exp(0, 4, 0);
    push_exp(1, 3, 100);
    push_exp(0, 4, 4);
    push_exp(1, 3, 103);
    push_exp(0, 2, 8);
    drive();
    drain(100, "burst_limit");
    use_b = 1'b0;
  endtask

  task automatic test_backpressure();
    int w0;
    int n;
    use_b = 1'b1;
    do_reset();
    push_src(1, 6, 200);
    push_exp(1, 4, 200);
    push_exp(0, 1, 300);
    push_exp(1, 2, 204);
    drive();
    w0 = writes;
    n  = 0;
    while ((writes - w0 < 2) && (n < 20)) begin
      step();
      n++;
    end
    drv_full = 1'b1;
    push_src(0, 1, 300);
    drive();
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++;
      if ({o_wr, o_rdy, o_busy, o_gid} !== {1'b0, 4'b0000, 1'b1, 3'd1}) begin
        errors++;
        $display("FAIL stall_%0d got wr=%b rdy=%b busy=%b gid=%0d, want wr=0 rdy=0000 busy=1 gid=1",
                 s, o_wr, o_rdy, o_busy, o_gid);
      end
      step();
    end
    drv_full = 1'b0;
    #1;
    checks++;
    if ({o_wr, o_x} !== {1'b1, 16'd202}) begin
      errors++;
      $display("FAIL stall_resume got wr=%b x=%h, want wr=1 x=00ca", o_wr, o_x);
    end
    drain(60, "backpressure");
    use_b = 1'b0;
  endtask

  task automatic test_reset_locked();
    int w0;
    int n;
    use_b = 1'b0;
    do_reset();
    push_src(2, 3, 400);
    push_exp(2, 3, 400);
    drive();
    w0 = writes;
    n  = 0;
    while ((writes - w0 < 1) && (n < 20)) begin
      step();
      n++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o_wr, o_busy, o_rdy, o_gid, o_x, o_y, o_z} !== '0) begin
      errors++;
      $display("FAIL midreset got wr=%b busy=%b rdy=%b gid=%0d x=%h y=%h z=%h, want all 0",
               o_wr, o_busy, o_rdy, o_gid, o_x, o_y, o_z);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // rr_ptr restarts at 0, so requester 1 goes before the restarted requester 2 packet.
    push_src(1, 1, 500);
    push_src(2, 3, 400);
    push_src(3, 1, 600);
    push_exp(1, 1, 500);
    push_exp(2, 3, 400);
    push_exp(3, 1, 600);
    drive();
    drain(60, "reset_restart");
  endtask

  task automatic test_stats();
    use_b = 1'b0;
    do_reset();
`ifdef ALIB_POINTS_ARB_STATS_EN
    push_src(1, 100, 0);
    push_exp(1, 100, 0);
    drive();
    drain(300, "stats_100");
    checks++;
    if (o_stat !== {16'd0, 16'd0, 16'd100, 16'd0}) begin
      errors++;
      $display("FAIL stat_100 got %h, want slice1=100 others 0", o_stat);
    end
    push_src(1, 69900, 100);
    push_exp(1, 69900, 100);
    drive();
    drain(75000, "stats_sat");
    checks++;
    if (o_stat !== {16'd0, 16'd0, 16'hFFFF, 16'd0}) begin
      errors++;
      $display("FAIL stat_saturate got %h, want slice1=ffff others 0", o_stat);
    end
`else
    push_src(1, 200, 0);
    push_exp(1, 200, 0);
    drive();
    drain(400, "stats_off");
    checks++;
    if (o_stat !== '0) begin
      errors++;
      $display("FAIL stat_disabled got %h, want 0", o_stat);
    end
`endif
    drv_clr = 1'b1;
    step();
    drv_clr = 1'b0;
    #1;
    checks++;
    if (o_stat !== '0) begin
      errors++;
      $display("FAIL stat_clear got %h, want 0", o_stat);
    end
  endtask

  initial begin
    use_b     = 1'b0;
    drv_valid = '0;
    drv_last  = '0;
    drv_x     = '0;
    drv_y     = '0;
    drv_z     = '0;
    drv_full  = 1'b0;
    drv_clr   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_reset_locked();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
